// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: sequential PC generation, a single outstanding imem request,
// and a DEPTH-entry {instruction, pc} queue towards decode, flushed by taken branches.
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     imem_req_o,
    output logic [31:0]              imem_addr_o,
    input  logic [31:0]              imem_rdata_i,
    input  logic                     imem_valid_i,
    input  logic                     is_branch_taken_i,
    input  logic [31:0]              branch_pc_i,
    output logic                     out_valid_o,
    output logic [31:0]              out_instruction_o,
    output logic [31:0]              out_pc_o,
    input  logic                     out_ready_i,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    logic [31:0]     instr_q [DEPTH];
    logic [31:0]     pc_q    [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d, count_after;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     outst_pc_q, outst_pc_d;
    logic            outst_q, outst_d;
    logic            drop_q, drop_d;
    logic            resp, push, pop, issue;

    always_comb begin
        resp        = imem_valid_i & outst_q;
        push        = resp & ~drop_q & ~is_branch_taken_i;
        pop         = (count_q != '0) & out_ready_i & ~is_branch_taken_i;
        count_after = count_q + CntW'(push) - CntW'(pop);
        // Issue only when the new request's response is guaranteed a free slot.
        issue       = ~is_branch_taken_i & (~outst_q | imem_valid_i) & (count_after < DepthCnt);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        outst_pc_d = outst_pc_q;
        drop_d     = drop_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (is_branch_taken_i) begin
            fetch_pc_d = branch_pc_i;
            outst_d    = outst_q & ~imem_valid_i;
            drop_d     = outst_q & ~imem_valid_i;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (resp) begin
                outst_d = 1'b0;
                drop_d  = 1'b0;
            end
            if (issue) begin
                outst_d    = 1'b1;
                outst_pc_d = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_after;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            outst_pc_q <= '0;
            outst_q    <= 1'b0;
            drop_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_pc_q <= outst_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else if (push) begin
            instr_q[wr_ptr_q] <= imem_rdata_i;
            pc_q[wr_ptr_q]    <= outst_pc_q;
        end
    end

    // Reset holds the issue logic in a "ready" state, so the strobe is masked explicitly.
    assign imem_req_o        = issue & ~rst_i;
    assign imem_addr_o       = fetch_pc_q;
    assign out_valid_o       = (count_q != '0);
    assign out_instruction_o = instr_q[rd_ptr_q];
    assign out_pc_o          = pc_q[rd_ptr_q];
    assign occupancy_o       = count_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue: a latency-modelled instruction memory and a
// queue-level scoreboard built from request epochs (bumped on every redirect and reset).
module tb_if_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int unsigned epoch;
        int unsigned due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk, rst;
    logic        imem_req, imem_valid, is_branch_taken, out_valid, out_ready;
    logic [31:0] imem_addr, imem_rdata, branch_pc, out_instruction, out_pc;
    logic [2:0]  occupancy;

    logic        imem_req2, out_valid2, valid2_q;
    logic [31:0] addr2, instr2, pc2, data2_q;
    logic [2:0]  occupancy2;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned epoch    = 0;
    int unsigned lat      = 1;
    int          n2       = 0;
    logic [31:0] fetch_pc = 32'h0;
    logic [31:0] exp2 [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    req_t        pending[$];
    ent_t        q[$];

    if_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .imem_req_o        (imem_req),
        .imem_addr_o       (imem_addr),
        .imem_rdata_i      (imem_rdata),
        .imem_valid_i      (imem_valid),
        .is_branch_taken_i (is_branch_taken),
        .branch_pc_i       (branch_pc),
        .out_valid_o       (out_valid),
        .out_instruction_o (out_instruction),
        .out_pc_o          (out_pc),
        .out_ready_i       (out_ready),
        .occupancy_o       (occupancy)
    );

    if_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4)) dut_wrap (
        .clk_i             (clk),
        .rst_i             (rst),
        .imem_req_o        (imem_req2),
        .imem_addr_o       (addr2),
        .imem_rdata_i      (data2_q),
        .imem_valid_i      (valid2_q),
        .is_branch_taken_i (1'b0),
        .branch_pc_i       (32'h0),
        .out_valid_o       (out_valid2),
        .out_instruction_o (instr2),
        .out_pc_o          (pc2),
        .out_ready_i       (1'b1),
        .occupancy_o       (occupancy2)
    );

    // Fixed 1-cycle memory for the wrap-around instance.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            valid2_q <= 1'b0;
            data2_q  <= '0;
        end else begin
            valid2_q <= imem_req2;
            data2_q  <= addr2 ^ 32'hDEAD_BEEF;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Called at posedge+1; leaves at the next posedge+1.
    task automatic step(input bit br, input logic [31:0] bpc, input bit rdy);
        bit   valid_now, push_exp, pop_exp, req_exp;
        int   size;
        req_t h;
        ent_t e;
        is_branch_taken = br;
        branch_pc       = bpc;
        out_ready       = rdy;
        valid_now       = (pending.size() > 0) && (pending[0].due <= cyc);
        imem_valid      = valid_now;
        imem_rdata      = valid_now ? pending[0].data : $urandom;
        #3;
        size = q.size();
        check_eq("occupancy", 32'(occupancy), 32'(size));
        check_eq("out_valid", 32'(out_valid), 32'(size != 0));
        if (size != 0) begin
            check_eq("out_pc", out_pc, q[0].pc);
            check_eq("out_instr", out_instruction, q[0].instr);
        end
        push_exp = valid_now && (pending[0].epoch == epoch) && !br;
        pop_exp  = (size != 0) && rdy && !br;
        req_exp  = !br && (pending.size() == 0 || valid_now)
                   && (size + int'(push_exp) - int'(pop_exp) < DEPTH);
        check_eq("imem_req", 32'(imem_req), 32'(req_exp));
        check_eq("imem_addr", imem_addr, fetch_pc);
        if (out_valid2 && n2 < 3) begin
            check_eq("wrap_pc", pc2, exp2[n2]);
            check_eq("wrap_instr", instr2, exp2[n2] ^ 32'hDEAD_BEEF);
            n2++;
        end
        if (pop_exp) void'(q.pop_front());
        if (valid_now) begin
            h = pending.pop_front();
            if (push_exp) begin
                e.pc    = h.addr;
                e.instr = h.data;
                q.push_back(e);
            end
        end
        if (br) begin
            q.delete();
            epoch++;
            fetch_pc = bpc;
        end
        if (imem_req) begin
            h.addr  = imem_addr;
            h.data  = $urandom;
            h.epoch = epoch;
            h.due   = cyc + lat;
            pending.push_back(h);
        end
        if (req_exp) fetch_pc = fetch_pc + 32'd4;
        check_eq("single_outstanding", 32'(pending.size() <= 1), 32'd1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Called at posedge+1; releases reset at a later posedge+1.
    task automatic do_reset(input bit keep_ghost);
        rst             = 1'b1;
        is_branch_taken = 1'b0;
        imem_valid      = 1'b0;
        out_ready       = 1'b0;
        if (keep_ghost && pending.size() > 0) pending[0].due = 0;
        else pending.delete();
        q.delete();
        epoch++;
        fetch_pc = 32'h0;
        #2;
        check_eq("rst_imem_req", 32'(imem_req), 32'd0);
        check_eq("rst_imem_addr", imem_addr, 32'h0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_instr", out_instruction, 32'h0);
        check_eq("rst_out_pc", out_pc, 32'h0);
        check_eq("rst_occupancy", 32'(occupancy), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        bit seen;
        rst             = 1'b1;
        imem_valid      = 1'b0;
        imem_rdata      = '0;
        is_branch_taken = 1'b0;
        branch_pc       = '0;
        out_ready       = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1'b0);

        // 1-cycle memory streaming into a ready consumer.
        lat = 1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 32'h0, 1'b1);
            check_eq("t1_occ_le1", 32'(occupancy <= 3'd1), 32'd1);
        end
        check_eq("wrap_count", 32'(n2), 32'd3);

        // Consumer stall fills the queue, then drains in order.
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b0);
        check_eq("t2_full_occ", 32'(occupancy), 32'd4);
        check_eq("t2_full_noreq", 32'(imem_req), 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 1'b1);

        // Redirect with three entries queued and one request still in flight.
        lat = 2;
        step(1'b1, 32'h0000_0040, 1'b0);
        n = 0;
        while (!(q.size() == 3 && pending.size() == 1 && pending[0].due > cyc) && n < 40) begin
            step(1'b0, 32'h0, 1'b0);
            n++;
        end
        check_eq("t3_setup_entries", 32'(q.size()), 32'd3);
        step(1'b1, 32'h0000_0100, 1'b0);
        check_eq("t3_flushed", 32'(out_valid), 32'd0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            seen = out_valid;
            if (!seen) begin
                step(1'b0, 32'h0, 1'b1);
                n++;
            end
        end
        check_eq("t3_first_pc", out_pc, 32'h0000_0100);
        for (int i = 0; i < 10; i++) step(1'b0, 32'h0, 1'b1);

        // Slow memory.
        lat = 3;
        for (int i = 0; i < 30; i++) step(1'b0, 32'h0, 1'b1);

        // Reset with a request in flight; memory answers right after release.
        lat = 4;
        n = 0;
        while (!(pending.size() == 1 && pending[0].due > cyc + 1) && n < 20) begin
            step(1'b0, 32'h0, 1'b1);
            n++;
        end
        check_eq("t6_setup_pending", 32'(pending.size()), 32'd1);
        do_reset(1'b1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            seen = out_valid;
            if (!seen) begin
                step(1'b0, 32'h0, 1'b1);
                n++;
            end
        end
        check_eq("t6_first_pc", out_pc, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            logic [31:0] bpc;
            if (i % 64 == 0) lat = $urandom_range(1, 3);
            bpc = $urandom;
            if ($urandom_range(0, 7) != 0) bpc[1:0] = 2'b00;
            if ($urandom_range(0, 299) == 0) do_reset(1'b0);
            step($urandom_range(0, 19) == 0, bpc, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
